// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: default sizes and the result-register state type.
package adder_arbiter_pkg;

   localparam int N_DEFAULT    = 32;
   localparam int NREQ_DEFAULT = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester/consumer bundle around the shared adder. The master side is the
// requesters plus the result consumer; the slave side is the arbiter itself.
interface adder_arbiter_if #(
   parameter int N    = 32,
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [N-1:0]      rsp_y;
   logic [IDW-1:0]    rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_y, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_y, rsp_id
   );
endinterface

// File: rtl/adder_arbiter_rr.sv
// Round-robin winner selection and the shared combinational adder.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);
   int  pos;
   logic found;

   // Scan from ptr upwards, wrapping modulo NREQ; the first active request wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int i = 0; i < NREQ; i++) begin
         pos = int'(ptr) + i;
         if (pos >= NREQ) begin
            pos = pos - NREQ;
         end
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = IDW'(pos);
         end
      end
   end
endmodule

module adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   // Plain modulo-2^N sum; the carry-out is intentionally dropped.
   always_comb begin
      y = a + b;
   end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NREQ requesters: round-robin grant, one registered sum per cycle.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int N    = N_DEFAULT,
   parameter int NREQ = NREQ_DEFAULT,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic           clk,
   input  logic           rst_n,
   adder_arbiter_if.slave bus
);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

   arb_state_t      state, state_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [N-1:0]    y_q;
   logic [IDW-1:0]  id_q;
   logic            can_accept;
   logic [NREQ-1:0] req_eff;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  win_idx;
   logic            any_gnt;
   logic [N-1:0]    a_sel, b_sel, sum;

   // Requests only count while the result slot is free or being drained, and never in reset.
   always_comb begin
      can_accept = (state == EMPTY) || bus.rsp_ready;
      req_eff    = (can_accept && rst_n) ? bus.req_valid : '0;
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req (req_eff),
      .ptr (ptr),
      .gnt (gnt),
      .idx (win_idx)
   );

   // Route the winner's operands to the single shared adder.
   always_comb begin
      a_sel = bus.req_a[int'(win_idx)*N +: N];
      b_sel = bus.req_b[int'(win_idx)*N +: N];
   end

   adder #(.N(N)) u_adder (
      .a (a_sel),
      .b (b_sel),
      .y (sum)
   );

   // Next state and pointer: a grant always fills the slot, a drain without grant empties it.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      any_gnt   = |gnt;
      if (any_gnt) begin
         state_nxt = FULL;
         ptr_nxt   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else if (state == FULL && bus.rsp_ready) begin
         state_nxt = EMPTY;
      end
   end

   // State, round-robin pointer and result register; reset discards any held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         ptr   <= '0;
         y_q   <= '0;
         id_q  <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (any_gnt) begin
            y_q  <= sum;
            id_q <= win_idx;
         end
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = (state == FULL);
   assign bus.rsp_y     = y_q;
   assign bus.rsp_id    = id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: the driver pushes expected sums on each grant,
// a negedge monitor pops them whenever a result is handed off.
module tb_adder_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;

   typedef struct {
      logic [N-1:0] y;
      logic [1:0]   id;
   } rsp_t;

   logic clk;
   logic rst_n;

   adder_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          compared   = 0;
   int          mismatched = 0;
   rsp_t        sb[$];
   logic [31:0] opA[NREQ];
   logic [31:0] opB[NREQ];

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive a new request/consume pattern just after the rising edge.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic r);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*N +: N] = opA[i];
         bus.req_b[i*N +: N] = opB[i];
      end
      bus.req_valid = v;
      bus.rsp_ready = r;
   endtask

   // Check the combinational grant and queue the expected registered result.
   task automatic expectGrant(input int k, input logic [31:0] expY);
      rsp_t e;
      #1;
      checkOutput($sformatf("grant%0d", k), 64'(bus.req_ready), 64'(4'b0001 << k));
      e.y  = expY;
      e.id = 2'(k);
      sb.push_back(e);
   endtask

   task automatic resetDut();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every handed-off result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_rsp: got y=%0h id=%0d expected none", bus.rsp_y, bus.rsp_id);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            checkOutput("rsp_y", 64'(bus.rsp_y), 64'(e.y));
            checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         opA[i] = '0;
         opB[i] = '0;
      end
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b0;
      rst_n         = 1'b0;

      // Reset with every requester asking
      #2;
      checkOutput("rst_ready", 64'(bus.req_ready), 64'h0);
      checkOutput("rst_valid", 64'(bus.rsp_valid), 64'h0);
      checkOutput("rst_y", 64'(bus.rsp_y), 64'h0);
      checkOutput("rst_id", 64'(bus.rsp_id), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = '0;
      rst_n         = 1'b1;

      // Single request: 5 + 7 from requester 0
      opA[0] = 32'd5;
      opB[0] = 32'd7;
      applyStimulus(4'b0001, 1'b1);
      expectGrant(0, 32'd12);
      applyStimulus(4'b0000, 1'b1);
      #1;
      checkOutput("single_valid", 64'(bus.rsp_valid), 64'h1);
      checkOutput("idle_ready", 64'(bus.req_ready), 64'h0);

      // Round-robin from a fresh pointer
      resetDut();
      for (int i = 0; i < NREQ; i++) begin
         opA[i] = 32'h100 * (i + 1);
         opB[i] = 32'(i + 1);
      end
      applyStimulus(4'b1111, 1'b1); expectGrant(0, 32'h101);
      applyStimulus(4'b1111, 1'b1); expectGrant(1, 32'h202);
      applyStimulus(4'b1111, 1'b1); expectGrant(2, 32'h303);
      applyStimulus(4'b1111, 1'b1); expectGrant(3, 32'h404);
      applyStimulus(4'b1111, 1'b1); expectGrant(0, 32'h101);
      applyStimulus(4'b0000, 1'b1);

      // Backpressure: fill with requester 1, stall three cycles, then drain and grant 2
      applyStimulus(4'b0010, 1'b0); expectGrant(1, 32'h202);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b1011, 1'b0);
         #1;
         checkOutput("bp_ready", 64'(bus.req_ready), 64'h0);
         checkOutput("bp_valid", 64'(bus.rsp_valid), 64'h1);
         checkOutput("bp_y", 64'(bus.rsp_y), 64'h202);
         checkOutput("bp_id", 64'(bus.rsp_id), 64'h1);
      end
      applyStimulus(4'b0100, 1'b1); expectGrant(2, 32'h303);
      applyStimulus(4'b0000, 1'b1);

      // Wrap-around sums (pointer is at 3 here)
      opA[3] = 32'hFFFF_FFFF;
      opB[3] = 32'h0000_0001;
      opA[0] = 32'h8000_0000;
      opB[0] = 32'h8000_0000;
      applyStimulus(4'b1000, 1'b1); expectGrant(3, 32'h0);
      applyStimulus(4'b0001, 1'b1); expectGrant(0, 32'h0);
      applyStimulus(4'b0000, 1'b1);

      // Reset mid-operation: hold a result with pointer at 2, then reset between edges
      applyStimulus(4'b0010, 1'b0); expectGrant(1, 32'h202);
      applyStimulus(4'b0000, 1'b0);
      #1;
      checkOutput("pre_rst_valid", 64'(bus.rsp_valid), 64'h1);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("midrst_valid", 64'(bus.rsp_valid), 64'h0);
      checkOutput("midrst_ready", 64'(bus.req_ready), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(4'b1111, 1'b1); expectGrant(0, 32'h0);
      applyStimulus(4'b0000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sb_empty", 64'(sb.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
